// File: rtl/video_scaler_pkg.sv
// -----------------------------------------------------------------------------
// video_scaler_pkg
// Shared definitions for the 2:1 video half scaler:
//   - RGB565 field widths and positions
//   - pair_sum_t: per-channel sum of two horizontally adjacent pixels (19 bits)
//   - scaler_state_e: line-tracking FSM states
//   - pair_sum / box_avg helpers used by the averaging filter
// -----------------------------------------------------------------------------
package video_scaler_pkg;

    localparam int RGB_W  = 16;
    localparam int R_W    = 5;
    localparam int G_W    = 6;
    localparam int B_W    = 5;
    localparam int R_LSB  = G_W + B_W;
    localparam int G_LSB  = B_W;
    localparam int PAIR_W = (R_W + 1) + (G_W + 1) + (B_W + 1);

    typedef logic [RGB_W-1:0] rgb565_t;

    // Each field is one bit wider than its channel so two samples never overflow.
    typedef struct packed {
        logic [R_W:0] r;
        logic [G_W:0] g;
        logic [B_W:0] b;
    } pair_sum_t;

    typedef enum logic [1:0] {
        WAIT_FS   = 2'd0,
        EVEN_LINE = 2'd1,
        ODD_LINE  = 2'd2
    } scaler_state_e;

    function automatic pair_sum_t pair_sum(input rgb565_t a, input rgb565_t b);
        pair_sum_t s;
        s.r = {1'b0, a[R_LSB +: R_W]} + {1'b0, b[R_LSB +: R_W]};
        s.g = {1'b0, a[G_LSB +: G_W]} + {1'b0, b[G_LSB +: G_W]};
        s.b = {1'b0, a[0 +: B_W]}     + {1'b0, b[0 +: B_W]};
        return s;
    endfunction

    // Sum of four samples per channel, divided by four with truncation.
    function automatic rgb565_t box_avg(input pair_sum_t top, input rgb565_t a,
                                        input rgb565_t b);
        logic [R_W+1:0] rs;
        logic [G_W+1:0] gs;
        logic [B_W+1:0] bs;
        rs = {1'b0, top.r} + {2'b00, a[R_LSB +: R_W]} + {2'b00, b[R_LSB +: R_W]};
        gs = {1'b0, top.g} + {2'b00, a[G_LSB +: G_W]} + {2'b00, b[G_LSB +: G_W]};
        bs = {1'b0, top.b} + {2'b00, a[0 +: B_W]}     + {2'b00, b[0 +: B_W]};
        return {R_W'(rs >> 2), G_W'(gs >> 2), B_W'(bs >> 2)};
    endfunction

endpackage

// File: rtl/scaler_line_ram.sv
// -----------------------------------------------------------------------------
// scaler_line_ram
// Simple dual-port line buffer: one write port, one read port, registered read
// (data appears the cycle after rd_en). rd_data holds while rd_en is low.
// Contents are not reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe
//   rd_addr  - read address
//   rd_data  - registered read data
// -----------------------------------------------------------------------------
module scaler_line_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 19,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_half_scaler.sv
// -----------------------------------------------------------------------------
// video_half_scaler
// Scales an IN_XSIZE x IN_YSIZE RGB565 frame down 2:1 in both axes.
// Build option SCALER_AVG_EN:
//   defined   - 2x2 box average; even lines store horizontal pair sums in a
//               line buffer (scaler_line_ram), odd lines combine them.
//   undefined - pure decimation: the pixel at (odd x, odd y) is passed out and
//               no line buffer is built.
// Ports:
//   vid_clk  - the only clock (rising edge)
//   vid_rst  - synchronous active-high reset
//   i_vs     - frame sync, rising edge starts a frame
//   i_de     - input data enable, one pixel per cycle while high
//   i_data   - input pixel (RGB565)
//   o_vs     - i_vs delayed one cycle
//   o_de     - one-cycle strobe per output pixel
//   o_data   - output pixel, valid with o_de
// Handshake: none; input is a free-running video stream (no backpressure),
// output is a write strobe o_de qualified data o_data.
// The FSM state is held in fsm_state for external checkers.
// -----------------------------------------------------------------------------
module video_half_scaler
    import video_scaler_pkg::*;
#(
    parameter int IN_XSIZE       = 1024,
    parameter int IN_YSIZE       = 768,
    parameter int VID_DATA_WIDTH = 16
) (
    input  logic                      vid_clk,
    input  logic                      vid_rst,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic [VID_DATA_WIDTH-1:0] i_data,
    output logic                      o_vs,
    output logic                      o_de,
    output logic [VID_DATA_WIDTH-1:0] o_data
);

    localparam int XW         = $clog2(IN_XSIZE + 1);
    localparam int YW         = $clog2(IN_YSIZE + 1);
    localparam int LINE_DEPTH = IN_XSIZE / 2;
    localparam int AW         = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;

    localparam logic [XW-1:0] X_LIMIT = XW'(IN_XSIZE);
    localparam logic [YW-1:0] Y_LIMIT = YW'(IN_YSIZE);

    scaler_state_e fsm_state;
    scaler_state_e fsm_next;

    logic          vs_d;
    logic          de_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic          vs_rise;
    logic          de_fall;
    logic          pix_ok;
    logic          out_fire;
    rgb565_t       out_pix;

    assign vs_rise = i_vs & ~vs_d;
    assign de_fall = ~i_de & de_d;

    // A pixel takes part only inside the active window of a started frame.
    // A pixel coinciding with a new frame sync is dropped: counters restart.
    assign pix_ok = (fsm_state != WAIT_FS) && !vs_rise && i_de &&
                    (x < X_LIMIT) && (y < Y_LIMIT);

    // The second pixel of each pair on an odd line produces one output.
    assign out_fire = pix_ok && (fsm_state == ODD_LINE) && x[0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge vid_clk) begin
        if (vid_rst) begin
            fsm_state <= WAIT_FS;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_state;
        if (vs_rise) begin
            fsm_next = EVEN_LINE;
        end else if (de_fall) begin
            case (fsm_state)
                EVEN_LINE: fsm_next = ODD_LINE;
                ODD_LINE:  fsm_next = EVEN_LINE;
                default:   fsm_next = fsm_state;
            endcase
        end
    end

    // ------------------------------------------------------ edge detection
    // vs_d resets high so a sync already high when reset releases is not
    // mistaken for a new frame start.
    always_ff @(posedge vid_clk) begin
        if (vid_rst) begin
            vs_d <= 1'b1;
            de_d <= 1'b0;
        end else begin
            vs_d <= i_vs;
            de_d <= i_de;
        end
    end

    // ------------------------------------------------------------ counters
    // Both counters saturate at their limit so overlong lines and extra
    // lines cannot wrap back into the active window.
    always_ff @(posedge vid_clk) begin
        if (vid_rst) begin
            x <= '0;
            y <= '0;
        end else if (vs_rise) begin
            x <= '0;
            y <= '0;
        end else if (fsm_state != WAIT_FS) begin
            if (de_fall) begin
                x <= '0;
                if (y != Y_LIMIT) begin
                    y <= y + 1'b1;
                end
            end else if (i_de && (x != X_LIMIT)) begin
                x <= x + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ datapath
`ifdef SCALER_AVG_EN
    logic              wr_fire;
    logic              rd_fire;
    logic [AW-1:0]     pair_addr;
    logic [PAIR_W-1:0] wr_word;
    logic [PAIR_W-1:0] rd_word;
    rgb565_t           first_pix;

    // Even lines write the pair sum when the second pixel arrives; odd lines
    // fetch the matching sum on the first pixel so it is ready one cycle later.
    assign wr_fire   = pix_ok && (fsm_state == EVEN_LINE) && x[0];
    assign rd_fire   = pix_ok && (fsm_state == ODD_LINE) && !x[0];
    assign pair_addr = AW'(x >> 1);
    assign wr_word   = pair_sum(first_pix, i_data);
    assign out_pix   = box_avg(pair_sum_t'(rd_word), first_pix, i_data);

    // Holds the even-x pixel of the current pair on either line type.
    always_ff @(posedge vid_clk) begin
        if (pix_ok && !x[0]) begin
            first_pix <= i_data;
        end
    end

    scaler_line_ram #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (PAIR_W),
        .AW    (AW)
    ) u_line_ram (
        .clk     (vid_clk),
        .wr_en   (wr_fire),
        .wr_addr (pair_addr),
        .wr_data (wr_word),
        .rd_en   (rd_fire),
        .rd_addr (pair_addr),
        .rd_data (rd_word)
    );
`else
    assign out_pix = i_data;
`endif

    // -------------------------------------------------------------- outputs
    always_ff @(posedge vid_clk) begin
        if (vid_rst) begin
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            o_vs <= i_vs;
            o_de <= out_fire;
            if (out_fire) begin
                o_data <= out_pix;
            end
        end
    end

endmodule
